// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
// The FIFO_ARB_STATS_EN build option is handled in fifo_wr_arbiter.sv.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_MAX_BURST = 4;

  // Width of a counter that must be able to hold the value max_burst.
  function automatic int cnt_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Rotating-priority selector: returns the first set req bit at or after ptr,
// wrapping modulo NUM_REQ.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   index
);

  int               c;
  logic [IDX_W-1:0] c_idx;

  // Scan from the farthest offset down so the nearest requester is written last.
  always_comb begin
    valid = 1'b0;
    index = '0;
    c     = 0;
    c_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      c = int'(ptr) + k;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      c_idx = IDX_W'(c);
      if (req[c_idx]) begin
        valid = 1'b1;
        index = c_idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers.
// Define FIFO_ARB_STATS_EN to add saturating per-producer push counters (grant_cnt).
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] data_in,
  input  logic                      full,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      push,
  output logic [DATA_W-1:0]         data_out,
  output logic                      busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]     grant_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = cnt_w(MAX_BURST);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] owner_inc;
  logic             pick_valid;
  logic             owner_req;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .index (pick_idx)
  );

  assign owner_req = req[owner_q];
  assign owner_inc = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    count_d  = count_q;
    busy     = (state_q == BURST);
    push     = busy && owner_req && !full;
    gnt      = '0;
    data_out = '0;
    if (push) begin
      gnt[owner_q] = 1'b1;
      data_out     = data_in[owner_q*DATA_W +: DATA_W];
    end
    case (state_q)
      IDLE: begin
        if (pick_valid && !full) begin
          state_d = BURST;
          owner_d = pick_idx;
          count_d = '0;
        end
      end
      BURST: begin
        // A dropped request ends the burst even while the FIFO is full.
        if (!owner_req) begin
          state_d = IDLE;
          ptr_d   = owner_inc;
        end else if (push) begin
          count_d = count_q + 1'b1;
          if (count_q == CNT_W'(MAX_BURST - 1)) begin
            state_d = IDLE;
            ptr_d   = owner_inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      count_q <= count_d;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
    logic [15:0] cnt_q;
    always_ff @(posedge clk) begin
      if (!rst) begin
        cnt_q <= '0;
      end else if (gnt[gi] && (cnt_q != 16'hFFFF)) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
    assign grant_cnt[gi*16 +: 16] = cnt_q;
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed scenarios queue expected pushes,
// a negedge monitor pops and compares them. FIFO_ARB_STATS_EN adds counter checks.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam logic [NR*DW-1:0] DIN = {8'hD3, 8'hC2, 8'hB1, 8'hA0};

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req;
  logic [NR*DW-1:0]  data_in;
  logic              full;
  logic [NR-1:0]     gnt;
  logic              push;
  logic [DW-1:0]     data_out;
  logic              busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic mon_en = 1'b0;

  typedef struct {
    logic [NR-1:0] gnt;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;
  exp_t exp_q[$];

`ifdef FIFO_ARB_STATS_EN
  logic [NR*16-1:0] gcnt;
  logic             s_rst = 1'b0;
  logic [NR-1:0]    s_req = '0;
  logic             s_full = 1'b0;
  logic [NR-1:0]    s_gnt;
  logic             s_push;
  logic [DW-1:0]    s_data_out;
  logic             s_busy;
  logic [NR*16-1:0] s_cnt;
  logic             s_en = 1'b0;
`endif

  fifo_wr_arbiter #(
    .NUM_REQ   (NR),
    .DATA_W    (DW),
    .MAX_BURST (MB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data_in   (data_in),
    .full      (full),
    .gnt       (gnt),
    .push      (push),
    .data_out  (data_out),
    .busy      (busy)
`ifdef FIFO_ARB_STATS_EN
    ,
    .grant_cnt (gcnt)
`endif
  );

`ifdef FIFO_ARB_STATS_EN
  fifo_wr_arbiter #(
    .NUM_REQ   (NR),
    .DATA_W    (DW),
    .MAX_BURST (16)
  ) dut_s (
    .clk       (clk),
    .rst       (s_rst),
    .req       (s_req),
    .data_in   (DIN),
    .full      (s_full),
    .gnt       (s_gnt),
    .push      (s_push),
    .data_out  (s_data_out),
    .busy      (s_busy),
    .grant_cnt (s_cnt)
  );

  always @(negedge clk) begin
    if (s_en) begin
      checks++;
      if (!$onehot0(s_gnt) || (s_push && s_full) || (s_push != (|s_gnt))) begin
        failures++;
        $display("FAIL stats_invariant cyc=%0d: gnt=%b push=%b full=%b", cyc, s_gnt, s_push, s_full);
      end
    end
  end
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] pd(input int i);
    logic [NR*DW-1:0] v;
    v = DIN;
    return v[i*DW +: DW];
  endfunction

  task automatic exp_push(input logic [NR-1:0] g, input logic [DW-1:0] d, input int c);
    exp_t e;
    e.gnt  = g;
    e.data = d;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic probe(input string tag, input logic eb, input logic ep,
                       input logic [NR-1:0] eg, input logic [DW-1:0] ed);
    #2;
    checks++;
    if (busy !== eb || push !== ep || gnt !== eg || data_out !== ed) begin
      failures++;
      $display("FAIL %s cyc=%0d: got busy=%b push=%b gnt=%b data=%h, want busy=%b push=%b gnt=%b data=%h",
               tag, cyc, busy, push, gnt, data_out, eb, ep, eg, ed);
    end
  endtask

  // Monitor: per-cycle invariants, then scoreboard pop on every push.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (!$onehot0(gnt) || (push && full) || (push != (|gnt)) || (!push && data_out != '0)) begin
        failures++;
        $display("FAIL invariant cyc=%0d: gnt=%b push=%b full=%b data=%h", cyc, gnt, push, full, data_out);
      end
      if (push) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_push cyc=%0d: got gnt=%b data=%h, want no push", cyc, gnt, data_out);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          $display("push cyc=%0d gnt=%b data=%h (expected cyc=%0d gnt=%b data=%h)",
                   cyc, gnt, data_out, e.cyc, e.gnt, e.data);
          if (gnt !== e.gnt || data_out !== e.data || cyc != e.cyc) begin
            failures++;
            $display("FAIL push_match: got cyc=%0d gnt=%b data=%h, want cyc=%0d gnt=%b data=%h",
                     cyc, gnt, data_out, e.cyc, e.gnt, e.data);
          end
        end
      end
    end
  end

  initial begin
    int t0;
    rst     = 1'b0;
    req     = '0;
    full    = 1'b0;
    data_in = DIN;
    step(2);
    probe("reset_state", 1'b0, 1'b0, '0, '0);
    rst    = 1'b1;
    mon_en = 1'b1;
    step(1);

    // All producers requesting: bursts of MB, one idle cycle between, order 0,1,2,3,0.
    t0  = cyc;
    req = 4'b1111;
    for (int b = 0; b < 5; b++)
      for (int w = 0; w < MB; w++)
        exp_push(4'(1 << (b % NR)), pd(b % NR), t0 + 1 + 5*b + w);
    step(5);
    probe("rr_idle_gap", 1'b0, 1'b0, '0, '0);
    step(20);
    req = '0;
    step(2);

    // Single producer, three distinct words, then request drops.
    t0 = cyc;
    req = 4'b0001;
    data_in = {pd(3), pd(2), pd(1), 8'h51};
    exp_push(4'b0001, 8'h51, t0 + 1);
    exp_push(4'b0001, 8'h52, t0 + 2);
    exp_push(4'b0001, 8'h53, t0 + 3);
    step(2);
    data_in = {pd(3), pd(2), pd(1), 8'h52};
    step(1);
    data_in = {pd(3), pd(2), pd(1), 8'h53};
    step(1);
    req = '0;
    data_in = DIN;
    probe("single_drop", 1'b1, 1'b0, '0, '0);
    step(2);

    // Owner 2 stalled by full for 5 cycles; count holds, 4 pushes total.
    t0 = cyc;
    req = 4'b0100;
    exp_push(4'b0100, pd(2), t0 + 1);
    exp_push(4'b0100, pd(2), t0 + 2);
    exp_push(4'b0100, pd(2), t0 + 8);
    exp_push(4'b0100, pd(2), t0 + 9);
    step(3);
    full = 1'b1;
    probe("full_stall", 1'b1, 1'b0, '0, '0);
    step(5);
    full = 1'b0;
    step(2);
    req = '0;
    probe("full_done", 1'b0, 1'b0, '0, '0);
    step(2);

    // Reset mid-burst of owner 3 (ptr was 3); afterwards 1010 must grant 1 first.
    t0 = cyc;
    req = 4'b1000;
    exp_push(4'b1000, pd(3), t0 + 1);
    exp_push(4'b1000, pd(3), t0 + 2);
    exp_push(4'b0010, pd(1), t0 + 5);
    exp_push(4'b0010, pd(1), t0 + 6);
    step(3);
    rst  = 1'b0;
    full = 1'b1;
    step(1);
    rst  = 1'b1;
    full = 1'b0;
    req  = 4'b1010;
    probe("rst_abort", 1'b0, 1'b0, '0, '0);
    step(3);
    req = '0;
    step(2);

    // Owner 2 drops after 2 pushes while req[3] (raised mid-burst) waits.
    t0 = cyc;
    req = 4'b0100;
    exp_push(4'b0100, pd(2), t0 + 1);
    exp_push(4'b0100, pd(2), t0 + 2);
    exp_push(4'b1000, pd(3), t0 + 5);
    exp_push(4'b1000, pd(3), t0 + 6);
    step(1);
    req = 4'b1100;
    step(2);
    req = 4'b1000;
    probe("owner_drop", 1'b1, 1'b0, '0, '0);
    step(1);
    probe("owner_drop_idle", 1'b0, 1'b0, '0, '0);
    step(3);
    req = '0;
    step(2);

    // Full blocks arbitration in IDLE; request drop under full still exits and advances ptr.
    t0 = cyc;
    req  = 4'b0001;
    full = 1'b1;
    exp_push(4'b0001, pd(0), t0 + 4);
    exp_push(4'b0010, pd(1), t0 + 8);
    probe("full_idle", 1'b0, 1'b0, '0, '0);
    step(3);
    full = 1'b0;
    step(2);
    full = 1'b1;
    step(1);
    req = '0;
    step(1);
    full = 1'b0;
    req  = 4'b0011;
    probe("drop_under_full", 1'b0, 1'b0, '0, '0);
    step(2);
    req = '0;
    step(3);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_pushes: got %0d outstanding, want 0", exp_q.size());
    end

`ifdef FIFO_ARB_STATS_EN
    // Counters were cleared by the mid-run reset; only later pushes remain.
    checks++;
    if (gcnt !== {16'd2, 16'd2, 16'd3, 16'd1}) begin
      failures++;
      $display("FAIL grant_cnt_main: got %h, want %h", gcnt, {16'd2, 16'd2, 16'd3, 16'd1});
    end
    s_en  = 1'b1;
    s_rst = 1'b1;
    s_req = 4'b0001;
    step(4375 * 17);
    s_req = '0;
    step(2);
    checks++;
    if (s_cnt !== {16'd0, 16'd0, 16'd0, 16'hFFFF}) begin
      failures++;
      $display("FAIL grant_cnt_sat: got %h, want %h", s_cnt, {16'd0, 16'd0, 16'd0, 16'hFFFF});
    end
    s_en = 1'b0;
`endif

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of producers (2..8) sharing one FIFO write port.
REQ-002 Parameter DATA_W, default 8, data width of each producer and of the FIFO write port.
REQ-003 Parameter MAX_BURST, default 4, maximum consecutive pushes per grant (1..16).
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst  input  1  synchronous active-low reset; sampled on posedge clk.
REQ-006 req  input  NUM_REQ  per-producer write request, held while producer has data.
REQ-007 data_in  input  NUM_REQ*DATA_W  packed producer data, slice i belongs to producer i.
REQ-008 full  input  1  FIFO full flag; no push is issued while it is high.
REQ-009 gnt  output  NUM_REQ  one-hot; gnt[i] high means data_in slice i is pushed this cycle.
REQ-010 push  output  1  FIFO write enable.
REQ-011 data_out  output  DATA_W  FIFO write data.
REQ-012 busy  output  1  high while in state BURST.

Function
REQ-013 The block SHALL implement two states: IDLE and BURST.
REQ-014 IDLE -> BURST SHALL occur at a clock edge where any req bit is high and full is low; owner SHALL be the first requester at or after ptr, scanning upward modulo NUM_REQ.
REQ-015 In IDLE, gnt, push and busy SHALL be 0; first push SHALL occur in the cycle after the IDLE->BURST edge (one-cycle arbitration latency).
REQ-016 In BURST, gnt[owner] and push SHALL be req[owner] AND NOT full, combinationally; all other gnt bits SHALL be 0.
REQ-017 data_out SHALL equal data_in slice owner when push is 1, and 0 otherwise.
REQ-018 The burst count SHALL increment on each push, hold while full is high, and reset to 0 on BURST entry.
REQ-019 BURST -> IDLE SHALL occur at the edge where req[owner] is 0, or where a push makes the count equal MAX_BURST; ptr SHALL then become (owner+1) mod NUM_REQ.
REQ-020 If full stays high in BURST, the block SHALL remain in BURST with no push and no timeout.
REQ-021 If req[owner] drops while full is high, the block SHALL still exit to IDLE and advance ptr.
REQ-022 Requests arriving while another owner is in BURST SHALL be ignored until IDLE is re-entered; no request SHALL be lost while req is held.
REQ-023 gnt SHALL never have more than one bit set, and push SHALL never be 1 when full is 1.

Reset
REQ-024 With rst low at a clock edge: state=IDLE, ptr=0, owner=0, count=0; gnt=0, push=0, data_out=0, busy=0 from the following cycle.
REQ-025 Reset asserted during BURST SHALL abort the burst with no further push; words already pushed are not retracted.

Configuration
REQ-026 With macro FIFO_ARB_STATS_EN defined, the block SHALL add output grant_cnt (NUM_REQ*16 bits): per-producer push counters, saturating at 16'hFFFF, cleared by reset.
REQ-027 Without FIFO_ARB_STATS_EN, grant_cnt and its counters SHALL NOT exist; all other behaviour SHALL be identical.

Structure
REQ-028 Package fifo_arb_pkg SHALL hold the state enum (IDLE, BURST), default NUM_REQ/DATA_W/MAX_BURST constants and the count width function.
REQ-029 Sub-module rr_picker SHALL be the combinational rotating-priority selector (inputs req, ptr; outputs valid, index).

Verification
REQ-030 Single producer: req=4'b0001, 3 words, full=0 -> push high for 3 cycles starting one cycle after req; gnt=4'b0001; data_out matches in order.
REQ-031 All req=4'b1111 held, MAX_BURST=4, full=0 -> bursts of 4 pushes granted 0,1,2,3,0 with one idle cycle between bursts.
REQ-032 Owner 2 in BURST, full raised for 5 cycles -> push=0, gnt=0, busy=1, count held; on full low, remaining pushes complete, total 4.
REQ-033 req[owner] dropped after 2 pushes while req[3]=1 -> IDLE next edge, ptr=owner+1, producer 3 pushes one cycle later.
REQ-034 rst low mid-burst -> next cycle all outputs 0, ptr=0; after release, req=4'b1010 grants producer 1 first.
REQ-035 FIFO_ARB_STATS_EN defined, 70000 pushes from producer 0 -> grant_cnt slice 0 = 16'hFFFF, other slices 0; checker confirms one-hot gnt and no push while full throughout.
